load_store_unit: RTL and testbench

//  Initiator side of the data-memory interface: sits between the EX/MEM stage and the

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_if.sv | 41 ++++
 rtl/lsu_align.sv | 37 +++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// error causes and the request legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } lsu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_FUNCT3,
      ERR_MISALIGN,
      ERR_RANGE
   } err_cause_e;

   // Priority: an illegal encoding is reported before alignment or range problems.
   function automatic err_cause_e checkRequest(input logic        we,
                                               input logic [2:0]  funct3,
                                               input logic [31:0] addr,
                                               input logic [31:0] limit);
      logic illegal;
      if (we)
         illegal = (funct3 > F3_W);
      else
         illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      if (illegal)
         return ERR_FUNCT3;
      if ((funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00))
         return ERR_MISALIGN;
      if (addr >= limit)
         return ERR_RANGE;
      return ERR_NONE;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus bundles around the load/store unit: the core-side request/response
// channel and the data-memory channel.
interface lsu_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport master (
      output mem_read, mem_write, mem_address, mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/lsu_align.sv
// Byte/half lane handling: extracts and extends load data, and merges store
// data into a previously read word for sub-word stores.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] word_i,
   input  logic [15:0] storeData_i,
   output logic [31:0] loadData_o,
   output logic [31:0] mergedWord_o
);

   logic [15:0] laneHalf;
   logic [7:0]  laneByte;

   // Shift the addressed lane down to bit 0 once; byte and half views share it.
   always_comb begin
      laneHalf = 16'(word_i >> {offset_i, 3'b000});
      laneByte = laneHalf[7:0];

      case (funct3_i)
         F3_B:    loadData_o = {{24{laneByte[7]}}, laneByte};
         F3_H:    loadData_o = {{16{laneHalf[15]}}, laneHalf};
         F3_BU:   loadData_o = {24'h000000, laneByte};
         F3_HU:   loadData_o = {16'h0000, laneHalf};
         default: loadData_o = word_i;
      endcase

      mergedWord_o = word_i;
      if (funct3_i == F3_B)
         mergedWord_o[{offset_i, 3'b000} +: 8] = storeData_i[7:0];
      else
         mergedWord_o[{offset_i[1], 4'b0000} +: 16] = storeData_i;
   end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory port: one request at a time, sub-word
// stores by read-modify-write, extended loads and access error reporting.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 1024
) (
   input logic        clk,
   input logic        rst_n,
   lsu_req_if.slave   req,
   lsu_mem_if.master  mem
);

   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

   lsu_state_e  state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] mergeWord_q, mergeWord_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   err_cause_e  reqCause;
   logic [31:0] alignIn;
   logic [31:0] loadData;
   logic [31:0] storeWord;

   assign reqCause = checkRequest(req.req_we, req.req_funct3, req.req_addr, ADDR_LIMIT);
   assign alignIn  = (state_q == S_LOAD) ? mem.mem_read_data : mergeWord_q;

   lsu_align u_align (
      .funct3_i     (funct3_q),
      .offset_i     (addr_q[1:0]),
      .word_i       (alignIn),
      .storeData_i  (wdata_q[15:0]),
      .loadData_o   (loadData),
      .mergedWord_o (storeWord)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         funct3_q    <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         mergeWord_q <= 32'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mergeWord_q <= mergeWord_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   // Store vs load is carried by the state itself, so only funct3/addr/wdata need latching.
   always_comb begin
      state_d     = state_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mergeWord_d = mergeWord_q;
      rdata_d     = rdata_q;
      err_d       = err_q;

      case (state_q)
         S_IDLE: begin
            if (req.req_valid) begin
               funct3_d = req.req_funct3;
               addr_d   = req.req_addr;
               wdata_d  = req.req_wdata;
               rdata_d  = 32'h0;
               err_d    = 1'b0;
               if (reqCause != ERR_NONE) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (!req.req_we)
                  state_d = S_LOAD;
               else if (req.req_funct3 == F3_W)
                  state_d = S_WRITE;
               else
                  state_d = S_RMW_RD;
            end
         end
         S_LOAD: begin
            rdata_d = loadData;
            state_d = S_RESP;
         end
         S_WRITE:  state_d = S_RESP;
         S_RMW_RD: begin
            mergeWord_d = mem.mem_read_data;
            state_d     = S_RMW_WR;
         end
         S_RMW_WR: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Moore outputs; the memory address is forced to zero outside an access.
   always_comb begin
      req.req_ready      = (state_q == S_IDLE);
      req.resp_valid     = (state_q == S_RESP);
      req.resp_rdata     = (state_q == S_RESP) ? rdata_q : 32'h0;
      req.resp_err       = (state_q == S_RESP) ? err_q : 1'b0;
      mem.mem_read       = (state_q == S_LOAD) || (state_q == S_RMW_RD);
      mem.mem_write      = (state_q == S_WRITE) || (state_q == S_RMW_WR);
      mem.mem_address    = 32'h0;
      mem.mem_write_data = 32'h0;

      if (state_q inside {S_LOAD, S_WRITE, S_RMW_RD, S_RMW_WR})
         mem.mem_address = {addr_q[31:2], 2'b00};
      if (state_q == S_WRITE)
         mem.mem_write_data = wdata_q;
      else if (state_q == S_RMW_WR)
         mem.mem_write_data = storeWord;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word-level memory, a queue-based
// reference model checked every cycle, and directed literal expectations.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   lsu_req_if reqIf ();
   lsu_mem_if memIf ();

   load_store_unit #(.MEM_WORDS(1024)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (reqIf),
      .mem   (memIf)
   );

   // Data memory: write on posedge, combinational read.
   logic [31:0] memArray [1024];
   always @(posedge clk)
      if (memIf.mem_write)
         memArray[memIf.mem_address[11:2]] <= memIf.mem_write_data;
   assign memIf.mem_read_data = memArray[memIf.mem_address[11:2]];

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   // Reference model: what each request must return and do to memory.
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          reads;
      int          writes;
      logic        isStore;
      int          idx;
      logic [31:0] newWord;
      int          acceptCycle;
   } expect_t;

   logic [31:0] modelMem [1024];
   expect_t     expQ [$];

   function automatic expect_t modelRequest(input logic we, input logic [2:0] f3,
                                            input logic [31:0] addr, input logic [31:0] wdata);
      expect_t     e;
      bit          legal;
      int          size;
      int          sh;
      logic [31:0] word;
      logic [31:0] val;
      logic [31:0] mask;
      e.rdata = 32'h0; e.err = 1'b0; e.lat = 0; e.reads = 0; e.writes = 0;
      e.isStore = 1'b0; e.idx = 0; e.newWord = 32'h0; e.acceptCycle = 0;
      legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = 1 << f3[1:0];
      if (!legal || (addr & 32'(size - 1)) != 0 || addr >= 32'd4096) begin
         e.err = 1'b1;
         e.lat = 1;
         return e;
      end
      e.idx = int'(addr >> 2);
      sh    = int'(addr[1:0]) * 8;
      word  = modelMem[e.idx];
      if (!we) begin
         val = word >> sh;
         if (size == 1) begin
            val = val & 32'hFF;
            if (f3 == 3'd0 && val[7]) val = val | 32'hFFFFFF00;
         end else if (size == 2) begin
            val = val & 32'hFFFF;
            if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF0000;
         end
         e.rdata = val;
         e.lat   = 2;
         e.reads = 1;
      end else begin
         e.isStore = 1'b1;
         e.writes  = 1;
         if (size == 4) begin
            e.newWord = wdata;
            e.lat     = 2;
         end else begin
            mask      = (size == 1 ? 32'hFF : 32'hFFFF) << sh;
            e.newWord = (word & ~mask) | ((wdata << sh) & mask);
            e.lat     = 3;
            e.reads   = 1;
         end
      end
      return e;
   endfunction

   int cycle = 0;
   int readCnt = 0;
   int writeCnt = 0;
   int respCount = 0;

   // Compare process: checks the DUT against the model on every cycle out of reset.
   always @(negedge clk) begin
      expect_t e;
      cycle++;
      if (!rst_n) begin
         expQ.delete();
         readCnt  = 0;
         writeCnt = 0;
      end else begin
         checkOutput("rd_wr_exclusive", 32'(memIf.mem_read & memIf.mem_write), 32'h0);
         readCnt  += int'(memIf.mem_read);
         writeCnt += int'(memIf.mem_write);
         if (reqIf.resp_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_resp", 32'h1, 32'h0);
            end else begin
               e = expQ.pop_front();
               checkOutput("resp_rdata", reqIf.resp_rdata, e.rdata);
               checkOutput("resp_err", 32'(reqIf.resp_err), 32'(e.err));
               checkOutput("latency", 32'(cycle - e.acceptCycle), 32'(e.lat));
               checkOutput("mem_reads", 32'(readCnt), 32'(e.reads));
               checkOutput("mem_writes", 32'(writeCnt), 32'(e.writes));
               if (e.isStore) begin
                  checkOutput("mem_word", memArray[e.idx], e.newWord);
                  modelMem[e.idx] = e.newWord;
               end
               respCount++;
            end
            readCnt  = 0;
            writeCnt = 0;
         end else begin
            checkOutput("quiet_rdata", reqIf.resp_rdata, 32'h0);
            checkOutput("quiet_err", 32'(reqIf.resp_err), 32'h0);
         end
         if (reqIf.req_valid && reqIf.req_ready) begin
            e = modelRequest(reqIf.req_we, reqIf.req_funct3, reqIf.req_addr, reqIf.req_wdata);
            e.acceptCycle = cycle;
            expQ.push_back(e);
         end
      end
   end

   // Issue one request from the posedge+1 phase and return its response.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
      bit got;
      rdata = 32'h0;
      err   = 1'b0;
      reqIf.req_valid  = 1'b1;
      reqIf.req_we     = we;
      reqIf.req_funct3 = f3;
      reqIf.req_addr   = addr;
      reqIf.req_wdata  = wdata;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (reqIf.req_ready) got = 1;
      end
      @(posedge clk);
      #1 reqIf.req_valid = 1'b0;
      if (!got) begin
         checkOutput("accept_timeout", 32'h1, 32'h0);
         return;
      end
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (reqIf.resp_valid) begin
            rdata = reqIf.resp_rdata;
            err   = reqIf.resp_err;
            got   = 1;
         end
      end
      if (!got) checkOutput("resp_timeout", 32'h1, 32'h0);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      req_t        burst [6];
      int          respBefore;
      bit          ok;

      for (int i = 0; i < 1024; i++) modelMem[i] = 32'h0;
      rst_n            = 1'b0;
      reqIf.req_valid  = 1'b0;
      reqIf.req_we     = 1'b0;
      reqIf.req_funct3 = 3'b000;
      reqIf.req_addr   = 32'h0;
      reqIf.req_wdata  = 32'h0;

      #12;
      checkOutput("reset_ready", 32'(reqIf.req_ready), 32'h1);
      checkOutput("reset_resp_valid", 32'(reqIf.resp_valid), 32'h0);
      checkOutput("reset_mem_read", 32'(memIf.mem_read), 32'h0);
      checkOutput("reset_mem_write", 32'(memIf.mem_write), 32'h0);
      checkOutput("reset_mem_address", memIf.mem_address, 32'h0);
      checkOutput("reset_mem_wdata", memIf.mem_write_data, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-word store then load.
      applyStimulus(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er);
      checkOutput("sw_err", 32'(er), 32'h0);
      applyStimulus(1'b0, F3_W, 32'h10, 32'h0, rd, er);
      checkOutput("lw_0x10", rd, 32'hDEADBEEF);

      // Sub-word read-modify-write stores.
      applyStimulus(1'b1, F3_W, 32'h20, 32'h11223344, rd, er);
      applyStimulus(1'b1, F3_B, 32'h21, 32'h123456AA, rd, er);
      checkOutput("sb_word", memArray[8], 32'h1122AA44);
      applyStimulus(1'b1, F3_H, 32'h22, 32'hFFFF8000, rd, er);
      checkOutput("sh_word", memArray[8], 32'h8000AA44);

      // Lane extraction and extension.
      applyStimulus(1'b1, F3_W, 32'h30, 32'h80FF7F01, rd, er);
      applyStimulus(1'b0, F3_B, 32'h31, 32'h0, rd, er);
      checkOutput("lb_0x31", rd, 32'h0000007F);
      applyStimulus(1'b0, F3_B, 32'h32, 32'h0, rd, er);
      checkOutput("lb_0x32", rd, 32'hFFFFFFFF);
      applyStimulus(1'b0, F3_BU, 32'h32, 32'h0, rd, er);
      checkOutput("lbu_0x32", rd, 32'h000000FF);
      applyStimulus(1'b0, F3_H, 32'h32, 32'h0, rd, er);
      checkOutput("lh_0x32", rd, 32'hFFFF80FF);
      applyStimulus(1'b0, F3_HU, 32'h32, 32'h0, rd, er);
      checkOutput("lhu_0x32", rd, 32'h000080FF);
      applyStimulus(1'b0, F3_B, 32'h33, 32'h0, rd, er);
      checkOutput("lb_0x33", rd, 32'hFFFFFF80);
      applyStimulus(1'b0, F3_H, 32'h30, 32'h0, rd, er);
      checkOutput("lh_0x30", rd, 32'h00007F01);

      // Error cases: no memory traffic, single-cycle latency.
      applyStimulus(1'b0, F3_W, 32'h12, 32'h0, rd, er);
      checkOutput("lw_misaligned_err", 32'(er), 32'h1);
      applyStimulus(1'b1, F3_H, 32'h13, 32'h0, rd, er);
      checkOutput("sh_misaligned_err", 32'(er), 32'h1);
      applyStimulus(1'b0, F3_W, 32'h1000, 32'h0, rd, er);
      checkOutput("lw_range_err", 32'(er), 32'h1);
      applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, rd, er);
      checkOutput("load_f3_011_err", 32'(er), 32'h1);
      applyStimulus(1'b0, 3'b110, 32'h10, 32'h0, rd, er);
      checkOutput("load_f3_110_err", 32'(er), 32'h1);
      applyStimulus(1'b1, 3'b011, 32'h10, 32'h0, rd, er);
      checkOutput("store_f3_011_err", 32'(er), 32'h1);
      checkOutput("store_f3_011_mem", memArray[4], 32'hDEADBEEF);

      // Last legal word.
      applyStimulus(1'b1, F3_W, 32'hFFC, 32'h0BADF00D, rd, er);
      checkOutput("sw_top_err", 32'(er), 32'h0);
      applyStimulus(1'b0, F3_W, 32'hFFC, 32'h0, rd, er);
      checkOutput("lw_top", rd, 32'h0BADF00D);

      // Back-to-back with req_valid held high throughout.
      burst[0] = '{1'b1, F3_W,  32'h40, 32'hCAFEF00D};
      burst[1] = '{1'b0, F3_W,  32'h40, 32'h0};
      burst[2] = '{1'b1, F3_B,  32'h41, 32'h0000005A};
      burst[3] = '{1'b0, F3_HU, 32'h40, 32'h0};
      burst[4] = '{1'b0, F3_W,  32'h41, 32'h0};
      burst[5] = '{1'b0, F3_W,  32'h40, 32'h0};
      respBefore = respCount;
      reqIf.req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         reqIf.req_we     = burst[i].we;
         reqIf.req_funct3 = burst[i].f3;
         reqIf.req_addr   = burst[i].addr;
         reqIf.req_wdata  = burst[i].wdata;
         ok = 0;
         for (int j = 0; j < 20 && !ok; j++) begin
            @(negedge clk);
            if (reqIf.req_ready) ok = 1;
         end
         if (!ok) checkOutput("burst_accept_timeout", 32'h1, 32'h0);
         @(posedge clk);
         #1;
      end
      reqIf.req_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("burst_resp_count", 32'(respCount - respBefore), 32'd6);
      checkOutput("burst_word", memArray[16], 32'hCAFE5A0D);

      // Reset in the middle of a read-modify-write.
      reqIf.req_valid  = 1'b1;
      reqIf.req_we     = 1'b1;
      reqIf.req_funct3 = F3_B;
      reqIf.req_addr   = 32'h20;
      reqIf.req_wdata  = 32'h00000077;
      ok = 0;
      for (int j = 0; j < 20 && !ok; j++) begin
         @(negedge clk);
         if (reqIf.req_ready) ok = 1;
      end
      @(posedge clk);
      #1 reqIf.req_valid = 1'b0;
      checkOutput("rmw_rd_mem_read", 32'(memIf.mem_read), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("abort_mem_read", 32'(memIf.mem_read), 32'h0);
      checkOutput("abort_mem_write", 32'(memIf.mem_write), 32'h0);
      checkOutput("abort_ready", 32'(reqIf.req_ready), 32'h1);
      checkOutput("abort_mem_address", memIf.mem_address, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_mem_word", memArray[8], 32'h8000AA44);
      applyStimulus(1'b0, F3_W, 32'h20, 32'h0, rd, er);
      checkOutput("after_abort_lw", rd, 32'h8000AA44);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
